// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
//   Definitions shared by the pipeline controller and the multiply sequencer:
//     mul_state_e    : multiply FSM states (2-bit encoding)
//     ALUOP_MUL      : decoded ALUOp value that requests a multiply
//     MUL_CYCLES_DEF : default number of shift-add iterations
//     ACC_W          : accumulator width (64 when MUL_HI_EN is defined, else 32)
//     mag32()        : two's-complement magnitude of a 32-bit word
//   Configuration macro: MUL_HI_EN
// -----------------------------------------------------------------------------
package mips_pkg;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_RUN  = 2'd1,
      MUL_DONE = 2'd2
   } mul_state_e;

   localparam logic [3:0] ALUOP_MUL      = 4'd8;
   localparam int         MUL_CYCLES_DEF = 32;

`ifdef MUL_HI_EN
   localparam int ACC_W = 64;
`else
   localparam int ACC_W = 32;
`endif

   // 0x80000000 maps to itself, which is the correct unsigned magnitude.
   function automatic logic [31:0] mag32(input logic [31:0] v);
      return v[31] ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/mul_shift_add.sv
// -----------------------------------------------------------------------------
// mul_shift_add
//   Shift-add multiply datapath: operand registers, accumulator and adder.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     load_i      : latch operands, clear accumulator
//     step_i      : perform one shift-add iteration
//     op_a_i      : multiplicand
//     op_b_i      : multiplier
//     product_o   : accumulated product (sign-corrected when MUL_HI_EN)
//   Configuration macro: MUL_HI_EN (64-bit signed product via magnitudes)
// -----------------------------------------------------------------------------
module mul_shift_add
   import mips_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic             step_i,
   input  logic [31:0]      op_a_i,
   input  logic [31:0]      op_b_i,
   output logic [ACC_W-1:0] product_o
);

   logic [ACC_W-1:0] mcand_q, mcand_d;
   logic [ACC_W-1:0] acc_q,   acc_d;
   logic [31:0]      mplier_q, mplier_d;
`ifdef MUL_HI_EN
   logic             neg_q, neg_d;
`endif

   // NOTE: every signal assigned here gets its hold value first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
`ifdef MUL_HI_EN
      neg_d    = neg_q;
`endif
      if (load_i) begin
`ifdef MUL_HI_EN
         mcand_d  = ACC_W'(mag32(op_a_i));
         mplier_d = mag32(op_b_i);
         neg_d    = op_a_i[31] ^ op_b_i[31];
`else
         mcand_d  = op_a_i;
         mplier_d = op_b_i;
`endif
         acc_d    = '0;
      end else if (step_i) begin
         if (mplier_q[0]) acc_d = acc_q + mcand_q;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
      end
   end

   // NOTE: these are a handful of flops, not a memory array, so all of them
   // are reset; sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
`ifdef MUL_HI_EN
         neg_q    <= 1'b0;
`endif
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
`ifdef MUL_HI_EN
         neg_q    <= neg_d;
`endif
      end
   end

`ifdef MUL_HI_EN
   assign product_o = neg_q ? (~acc_q + 64'd1) : acc_q;
`else
   assign product_o = acc_q;
`endif

endmodule

// File: rtl/mul_sequencer.sv
// -----------------------------------------------------------------------------
// mul_sequencer
//   Multi-cycle MUL unit for the EX stage. Owns the IDLE/RUN/DONE FSM, the
//   iteration counter and the pipeline handshake; the arithmetic lives in
//   mul_shift_add. Start-to-Done latency is MUL_CYCLES+1 cycles.
//   Ports:
//     Clk, Reset_n : clock, asynchronous active-low reset
//     Start        : multiply request (ignored unless IDLE)
//     OpA, OpB     : multiplicand, multiplier
//     Flush        : abort; wins over Start
//     Stall        : freezes upstream pipeline while the multiply is pending
//     Busy         : high in RUN
//     Done         : one-cycle pulse, Result valid
//     Result       : low word of product, held until the next completion
//     Hi           : high word of signed product (MUL_HI_EN only)
//   Configuration macro: MUL_HI_EN
// -----------------------------------------------------------------------------
module mul_sequencer
   import mips_pkg::*;
#(
   parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        Start,
   input  logic [31:0] OpA,
   input  logic [31:0] OpB,
   input  logic        Flush,
   output logic        Stall,
   output logic        Busy,
   output logic        Done,
`ifdef MUL_HI_EN
   output logic [31:0] Hi,
`endif
   output logic [31:0] Result
);

   localparam int               CNT_W    = $clog2(MUL_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

   mul_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      result_q;
`ifdef MUL_HI_EN
   logic [31:0]      hi_q;
`endif
   logic             load, step, accept;
   logic [ACC_W-1:0] product;

   assign accept = (state_q == MUL_IDLE) && Start && !Flush;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      step    = 1'b0;
      unique case (state_q)
         MUL_IDLE: if (accept) begin
            load    = 1'b1;
            cnt_d   = '0;
            state_d = MUL_RUN;
         end
         MUL_RUN: begin
            step  = 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_d = MUL_DONE;
         end
         MUL_DONE: state_d = MUL_IDLE;
         default:  state_d = MUL_IDLE;
      endcase
      if (Flush) begin
         state_d = MUL_IDLE;
         step    = 1'b0;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q  <= MUL_IDLE;
         cnt_q    <= '0;
         result_q <= '0;
`ifdef MUL_HI_EN
         hi_q     <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (Done) begin
            result_q <= product[31:0];
`ifdef MUL_HI_EN
            hi_q     <= product[63:32];
`endif
         end
      end
   end

   mul_shift_add u_dp (
      .clk       (Clk),
      .rst_n     (Reset_n),
      .load_i    (load),
      .step_i    (step),
      .op_a_i    (OpA),
      .op_b_i    (OpB),
      .product_o (product)
   );

   // Reset_n gates the accept term so Stall is low during reset even if a
   // request is already on Start.
   assign Stall  = Reset_n && !Flush && (accept || state_q == MUL_RUN);
   assign Busy   = (state_q == MUL_RUN);
   assign Done   = (state_q == MUL_DONE) && !Flush;
   // The product is presented straight from the datapath in the Done cycle,
   // so a Flush in DONE leaves the held value untouched.
   assign Result = Done ? product[31:0] : result_q;
`ifdef MUL_HI_EN
   assign Hi     = Done ? product[63:32] : hi_q;
`endif

endmodule
